cordic_post: RTL

- Output stage of the CORDIC datapath.
- Takes final x/y/z (Q16.16) and the mode select from the last CORDIC iteration stage.
- Applies CORDIC gain compensation, rounds and saturates to 16-bit results, and buffers them in a small FIFO.
- Results leave through a valid/ready handshake toward the system bus.
- The upstream pipeline cannot stall, so buffer overflow is flagged rather than back-pressured.

---
 rtl/cordic_pkg.sv | 29 ++
 rtl/cordic_post_if.sv | 30 +++
 rtl/cordic_post_fifo.sv | 69 ++++++
 rtl/cordic_post.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, result-entry layout and saturation helper for the CORDIC output stage.
package cordic_pkg;

    localparam logic [31:0] CORDIC_K_GAIN = 32'h00009B75;  // 0.607253 in Q16.16
    localparam int          CORDIC_FRAC   = 16;
    localparam int          SEL_VECTORING = 3;

    localparam logic [15:0] Q2_14_MAX = 16'h7FFF;
    localparam logic [15:0] Q2_14_MIN = 16'h8000;

    typedef struct packed {
        logic [15:0] result_a;
        logic [15:0] result_b;
        logic [3:0]  select;
    } result_t;

    localparam int RESULT_W = $bits(result_t);

    function automatic logic [15:0] sat16(input logic signed [32:0] v);
        if (v > 33'sd32767) begin
            return Q2_14_MAX;
        end else if (v < -33'sd32768) begin
            return Q2_14_MIN;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/cordic_post_if.sv
// Bus between the last CORDIC iteration stage, cordic_post and the result consumer.
interface cordic_post_if;

    logic        valid_in;
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic [31:0] z_in;
    logic [3:0]  select_in;

    // valid_in has no ready: the upstream pipeline never stalls. On the result side
    // an entry transfers on a rising edge where out_valid && out_ready; while
    // out_valid is high and out_ready low, result_a/result_b/select_out are held.
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result_a;
    logic [15:0] result_b;
    logic [3:0]  select_out;
    logic        overflow;

    modport master (
        output valid_in, x_in, y_in, z_in, select_in, out_ready,
        input  out_valid, result_a, result_b, select_out, overflow
    );

    modport slave (
        input  valid_in, x_in, y_in, z_in, select_in, out_ready,
        output out_valid, result_a, result_b, select_out, overflow
    );

endinterface

// File: rtl/cordic_post_fifo.sv
// Synchronous show-ahead FIFO; drops a push when full without a pop and pulses drop.
module cordic_post_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             drop
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] last_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == FULL_CNT);
        do_pop  = pop && !empty;
        // a pop frees the slot the same edge, so a full FIFO can still accept
        do_push = push && (!full || do_pop);
        drop    = push && full && !do_pop;
        head    = empty ? last_q : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // remember what was shown so the outputs freeze once the FIFO drains
            if (!empty) begin
                last_q <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/cordic_post.sv
// CORDIC output stage: gain compensation, rounding/saturation to 16 bits, output FIFO.
// Optional macro CORDIC_POST_OVF_CNT_EN adds a saturating ovf_count of dropped results.
module cordic_post
    import cordic_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] K_GAIN     = CORDIC_K_GAIN,
    parameter int          FRAC       = CORDIC_FRAC
) (
    input  logic          clk,
    input  logic          rst_n,
    cordic_post_if.slave  bus
`ifdef CORDIC_POST_OVF_CNT_EN
    ,
    output logic [15:0]   ovf_count
`endif
);

    localparam logic signed [63:0] RND       = 64'sd1 <<< (FRAC - 1);
    localparam int                 ROT_SHIFT = FRAC - 14;

    function automatic logic signed [32:0] rshift_round(input logic [31:0] v, input int n);
        logic signed [32:0] w;
        w = $signed({v[31], v}) + (33'sd1 <<< (n - 1));
        return w >>> n;
    endfunction

    // input capture ahead of the multiplier
    logic        in_vld;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic [31:0] in_z;
    logic [3:0]  in_sel;

    logic        s1_vld;
    logic [31:0] s1_xs;
    logic [31:0] s1_ys;
    logic [31:0] s1_z;
    logic [3:0]  s1_sel;

    logic        s2_vld;
    result_t     s2_entry;

    logic signed [63:0] x64;
    logic signed [63:0] y64;
    logic signed [63:0] k64;
    logic signed [63:0] px;
    logic signed [63:0] py;
    logic [31:0]        xs_next;
    logic [31:0]        ys_next;
    result_t            fmt_next;

    result_t fifo_head;
    logic    fifo_empty;
    logic    fifo_drop;
    logic    fifo_pop;
    logic    overflow_q;

    always_comb begin
        x64     = {{32{in_x[31]}}, in_x};
        y64     = {{32{in_y[31]}}, in_y};
        k64     = {{32{K_GAIN[31]}}, K_GAIN};
        px      = x64 * k64;
        py      = y64 * k64;
        xs_next = 32'((px + RND) >>> FRAC);
        ys_next = 32'((py + RND) >>> FRAC);
    end

    always_comb begin
        fmt_next.select = s1_sel;
        if (s1_sel[SEL_VECTORING]) begin
            fmt_next.result_a = sat16(rshift_round(s1_xs, FRAC));
            fmt_next.result_b = sat16(rshift_round(s1_z, FRAC));
        end else begin
            fmt_next.result_a = sat16(rshift_round(s1_xs, ROT_SHIFT));
            fmt_next.result_b = sat16(rshift_round(s1_ys, ROT_SHIFT));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_vld <= 1'b0;
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            in_vld <= bus.valid_in;
            s1_vld <= in_vld;
            s2_vld <= s1_vld;
        end
    end

    // data registers carry no reset: the valid bits alone decide what is live
    always_ff @(posedge clk) begin
        in_x     <= bus.x_in;
        in_y     <= bus.y_in;
        in_z     <= bus.z_in;
        in_sel   <= bus.select_in;
        s1_xs    <= xs_next;
        s1_ys    <= ys_next;
        s1_z     <= in_z;
        s1_sel   <= in_sel;
        s2_entry <= fmt_next;
    end

    assign fifo_pop = !fifo_empty && bus.out_ready;

    cordic_post_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RESULT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s2_vld),
        .push_data (s2_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (fifo_drop) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef CORDIC_POST_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else if (fifo_drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign ovf_count = ovf_cnt_q;
`endif

    assign bus.out_valid  = !fifo_empty;
    assign bus.result_a   = fifo_head.result_a;
    assign bus.result_b   = fifo_head.result_b;
    assign bus.select_out = fifo_head.select;
    assign bus.overflow   = overflow_q;

endmodule
